// File: rtl/fpu_pkg.sv
// Purpose: shared widths, biases, FSM states, status flags for custom-float -> IEEE conversion.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fpu_pkg;

   // Custom float layout: sign / 10-bit exponent (bias 511) / 21-bit mantissa
   localparam int CF_SIGN_W   = 1;
   localparam int CF_EXP_W    = 10;
   localparam int CF_MANT_W   = 21;

   // IEEE-754 single layout
   localparam int IEEE_SIGN_W = 1;
   localparam int IEEE_EXP_W  = 8;
   localparam int IEEE_MANT_W = 23;

   localparam int CF_BIAS     = 511;
   localparam int IEEE_BIAS   = 127;
   localparam int BIAS_DIFF   = CF_BIAS - IEEE_BIAS;   // 384

   // Denormal significand is hidden bit + mantissa + 2 pad bits
   localparam int SIG_W       = 1 + CF_MANT_W + 2;     // 24
   localparam int SHIFT_MAX   = 24;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SHIFT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // status_out bit positions
   localparam int ST_EXACT     = 0;
   localparam int ST_OVERFLOW  = 1;
   localparam int ST_UNDERFLOW = 2;
   localparam int ST_INEXACT   = 3;

   localparam logic [3:0] FLAG_EXACT     = 4'(1 << ST_EXACT);
   localparam logic [3:0] FLAG_OVERFLOW  = 4'(1 << ST_OVERFLOW);
   localparam logic [3:0] FLAG_UNDERFLOW = 4'(1 << ST_UNDERFLOW);
   localparam logic [3:0] FLAG_INEXACT   = 4'(1 << ST_INEXACT);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic                 sign;
      logic [CF_EXP_W-1:0]  exp;
      logic [CF_MANT_W-1:0] mant;
   } cfloat_t;

endpackage

// File: rtl/fpu_custom_to_ieee.sv
// Purpose: convert one custom float (bias 511, 21-bit mantissa) to IEEE single, truncating.
// Latency: result valid 2 cycles after accept, 2+k for denormals (k = right-shift count, max 24).
// Backpressure: single-entry; ready_out only in IDLE, result held in DONE until ready_in.
module fpu_custom_to_ieee
   import fpu_pkg::*;
(
   input  logic        clock_100KHz,
   input  logic        reset,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic [31:0] data_in,
   output logic        valid_out,
   input  logic        ready_in,
   output logic [31:0] data_out,
   output logic [3:0]  status_out
);

   localparam int E_W = 12;
   localparam logic signed [E_W-1:0] DIFF_S = E_W'(BIAS_DIFF);

   state_t          state, state_nxt;
   cfloat_t         in_q, in_nxt;
   logic [SIG_W-1:0] sig_q, sig_nxt;
   logic [4:0]      k_q, k_nxt;
   logic            sticky_q, sticky_nxt;
   logic [31:0]     data_nxt;
   logic [3:0]      status_nxt;

   // Rebased exponent and the raw (unsaturated) denormal shift count
   logic signed [E_W-1:0] e;
   logic signed [E_W-1:0] k_full;

   assign e         = $signed({2'b00, in_q.exp}) - DIFF_S;
   assign k_full    = 12'sd1 - e;
   assign valid_out = (state == DONE);

   // State register; reset aborts any in-flight conversion
   always_ff @(posedge clock_100KHz) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and datapath next values; outputs hold unless a result is produced
   always_comb begin
      state_nxt  = state;
      in_nxt     = in_q;
      sig_nxt    = sig_q;
      k_nxt      = k_q;
      sticky_nxt = sticky_q;
      data_nxt   = data_out;
      status_nxt = status_out;

      case (state)
         IDLE: begin
            if (valid_in && ready_out) begin
               in_nxt    = cfloat_t'(data_in);
               state_nxt = DECODE;
            end
         end

         DECODE: begin
            if (in_q.exp == '0) begin
               // Zero: mantissa ignored, sign kept
               data_nxt   = {in_q.sign, 31'b0};
               status_nxt = FLAG_EXACT;
               state_nxt  = DONE;
            end else if (in_q.exp == '1) begin
               // Inf / NaN
               data_nxt   = (in_q.mant == '0) ? {in_q.sign, 8'hFF, 23'b0} : QNAN;
               status_nxt = FLAG_INEXACT;
               state_nxt  = DONE;
            end else if (e >= 12'sd255) begin
               data_nxt   = {in_q.sign, 8'hFF, 23'b0};
               status_nxt = FLAG_OVERFLOW;
               state_nxt  = DONE;
            end else if (e >= 12'sd1) begin
               data_nxt   = {in_q.sign, e[7:0], in_q.mant, 2'b00};
               status_nxt = FLAG_EXACT;
               state_nxt  = DONE;
            end else begin
               // Denormal: shift the explicit significand right by 1-e (capped)
               sig_nxt    = {1'b1, in_q.mant, 2'b00};
               k_nxt      = (k_full > 12'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : k_full[4:0];
               sticky_nxt = 1'b0;
               state_nxt  = SHIFT;
            end
         end

         SHIFT: begin
            sig_nxt    = sig_q >> 1;
            sticky_nxt = sticky_q | sig_q[0];
            k_nxt      = k_q - 5'd1;
            // The last shift and the result write share one edge
            if (k_q <= 5'd1) begin
               data_nxt   = {in_q.sign, 8'h00, sig_nxt[22:0]};
               status_nxt = FLAG_UNDERFLOW | (sticky_nxt ? FLAG_INEXACT : 4'b0000);
               state_nxt  = DONE;
            end
         end

         DONE: begin
            if (ready_in) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and handshake registers; ready_out tracks the state being entered
   always_ff @(posedge clock_100KHz) begin
      if (!reset) begin
         in_q       <= '0;
         sig_q      <= '0;
         k_q        <= '0;
         sticky_q   <= 1'b0;
         data_out   <= '0;
         status_out <= '0;
         ready_out  <= 1'b0;
      end else begin
         in_q       <= in_nxt;
         sig_q      <= sig_nxt;
         k_q        <= k_nxt;
         sticky_q   <= sticky_nxt;
         data_out   <= data_nxt;
         status_out <= status_nxt;
         ready_out  <= (state_nxt == IDLE);
      end
   end

endmodule
